// File: rtl/dmem_arbiter.sv
// Arbiter that shares one single-port RAM between instruction fetch (I) and MEM-stage (D) requesters.
// Each access is latched, driven for WAIT_CYCLES RAM cycles, and answered with a one-cycle ack.
module dmem_arbiter #(
    parameter int WAIT_CYCLES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    output logic        i_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_stall,
    output logic        ram_ce,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    localparam logic [3:0] LP_WAIT_LOAD  = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_LIMIT);

    state_t      r_state;
    state_t      w_state_nxt;
    owner_t      r_owner;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;
    logic [3:0]  r_wait_cnt;
    logic [3:0]  r_starve_cnt;

    logic        w_starved;
    logic        w_grant_d;
    logic        w_grant_i;
    logic        w_last_wait;

    // I is forced only once D has won STARVE_LIMIT times in a row over a waiting fetch.
    assign w_starved   = i_req && (r_starve_cnt == LP_STARVE_MAX);
    assign w_last_wait = (r_state == ST_ACCESS) && (r_wait_cnt == 4'd0);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_d   = 1'b0;
        w_grant_i   = 1'b0;
        ram_ce      = 1'b0;
        ram_we      = 1'b0;
        i_ack       = 1'b0;
        d_ack       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (d_req && !w_starved) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end else if (i_req) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                ram_ce = 1'b1;
                ram_we = r_we;
                if (r_wait_cnt == 4'd0) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                i_ack       = (r_owner == OWN_I);
                d_ack       = (r_owner == OWN_D);
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the rdata registers are part of the reset set, so an aborted access leaves them at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner      <= OWN_NONE;
            r_we         <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_i_rdata    <= 32'd0;
            r_d_rdata    <= 32'd0;
            r_wait_cnt   <= 4'd0;
            r_starve_cnt <= 4'd0;
        end else begin
            if (w_grant_d || w_grant_i) begin
                r_owner    <= w_grant_d ? OWN_D : OWN_I;
                r_addr     <= w_grant_d ? d_addr : i_addr;
                r_we       <= w_grant_d && d_we;
                r_wdata    <= d_wdata;
                r_wait_cnt <= LP_WAIT_LOAD;
            end

            if (w_grant_d) begin
                if (!i_req) begin
                    r_starve_cnt <= 4'd0;
                end else if (r_starve_cnt != LP_STARVE_MAX) begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end
            end else if (w_grant_i) begin
                r_starve_cnt <= 4'd0;
            end

            if ((r_state == ST_ACCESS) && (r_wait_cnt != 4'd0)) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end

            // Stores leave d_rdata untouched; only the owning port's register captures.
            if (w_last_wait) begin
                if (r_owner == OWN_I) begin
                    r_i_rdata <= ram_rdata;
                end else if (!r_we) begin
                    r_d_rdata <= ram_rdata;
                end
            end
        end
    end

    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign i_stall   = i_req && !i_ack;
    assign d_stall   = d_req && !d_ack;

endmodule
